// File: rtl/csr_reg_bank.sv
// -----------------------------------------------------------------------------
// csr_reg_bank
//
// A small control/status register block on a simple strobe/ack bus.
//
// Register map (offset = sys_addr - BASE_ADDR, N = NUM_SCRATCH):
//   0 .. N-1 : SCRATCH    read/write
//   N        : VER_MAJOR  read only
//   N+1      : VER_MINOR  read only
//   N+2      : CTRL       read/write, mirrored on ctrl_out
//   N+3      : STATUS     sticky event bits, write 1 to clear
//   N+4      : IRQ_EN     read/write interrupt mask
// Anything below BASE_ADDR or at offset N+5 and above is an error access.
//
// Build option:
//   CSR_WLOCK_EN  When defined, CTRL[DATA_W-1] is a write lock. Once set,
//                 writes to SCRATCH, CTRL and IRQ_EN are refused with an error
//                 until reset. STATUS clears stay allowed. When undefined,
//                 CTRL[DATA_W-1] is an ordinary register bit.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   sys_addr       bus address
//   sys_data_in    write data
//   sys_data_out   read data, held between reads
//   sys_read_write 0 = read, 1 = write
//   sys_strobe     level request, held until sys_ack
//   sys_ack        one-cycle completion, one cycle after acceptance
//   sys_err        error flag, valid with sys_ack
//   evt_in         single-cycle event pulses, latched into STATUS
//   ctrl_out       current CTRL register value
//   irq            registered OR of STATUS & IRQ_EN
// -----------------------------------------------------------------------------
module csr_reg_bank #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter int                NUM_SCRATCH = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 8'h00,
  parameter logic [7:0]        VER_MAJOR   = 8'h02,
  parameter logic [7:0]        VER_MINOR   = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] sys_addr,
  input  logic [DATA_W-1:0] sys_data_in,
  output logic [DATA_W-1:0] sys_data_out,
  input  logic              sys_read_write,
  input  logic              sys_strobe,
  output logic              sys_ack,
  output logic              sys_err,
  input  logic [DATA_W-1:0] evt_in,
  output logic [DATA_W-1:0] ctrl_out,
  output logic              irq
);

  localparam int          SIDX_W      = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
  localparam logic [31:0] N_L         = 32'(NUM_SCRATCH);
  localparam logic [DATA_W-1:0] VER_MAJ_VAL = DATA_W'(VER_MAJOR);
  localparam logic [DATA_W-1:0] VER_MIN_VAL = DATA_W'(VER_MINOR);

  logic                strobe_prev;
  logic                accept;
  logic                ack_q;
  logic                err_q;

  logic [ADDR_W-1:0]   offset;
  logic [31:0]         offset_w;
  logic                below_base;
  logic                addr_valid;
  logic                hit_scratch;
  logic                hit_ver_major;
  logic                hit_ver_minor;
  logic                hit_ctrl;
  logic                hit_status;
  logic                hit_irq_en;
  logic [SIDX_W-1:0]   scratch_idx;

  logic [DATA_W-1:0]   scratch [NUM_SCRATCH];
  logic [DATA_W-1:0]   ctrl;
  logic [DATA_W-1:0]   status;
  logic [DATA_W-1:0]   irq_en;
  logic [DATA_W-1:0]   read_val;
  logic [DATA_W-1:0]   w1c_mask;

  logic                wr_locked;
  logic                wr_err;
  logic                txn_err;
  logic                wr_ok;

  // Address decode. The subtraction wraps, so addresses below the base are
  // caught by an explicit compare rather than relying on the wrapped offset.
  always_comb begin
    offset        = sys_addr - BASE_ADDR;
    offset_w      = 32'(offset);
    below_base    = (sys_addr < BASE_ADDR);
    addr_valid    = !below_base && (offset_w < (N_L + 32'd5));
    hit_scratch   = !below_base && (offset_w < N_L);
    hit_ver_major = !below_base && (offset_w == N_L);
    hit_ver_minor = !below_base && (offset_w == (N_L + 32'd1));
    hit_ctrl      = !below_base && (offset_w == (N_L + 32'd2));
    hit_status    = !below_base && (offset_w == (N_L + 32'd3));
    hit_irq_en    = !below_base && (offset_w == (N_L + 32'd4));
    scratch_idx   = offset[SIDX_W-1:0];
  end

  // A request is taken only on the rising edge of the strobe level, so a
  // strobe that stays high after its ack cannot start a second transaction.
  assign accept = sys_strobe && !strobe_prev;

`ifdef CSR_WLOCK_EN
  // Lock bit blocks configuration writes; STATUS clears are still allowed.
  assign wr_locked = ctrl[DATA_W-1] && (hit_scratch || hit_ctrl || hit_irq_en);
`else
  assign wr_locked = 1'b0;
`endif

  always_comb begin
    wr_err  = sys_read_write && (hit_ver_major || hit_ver_minor || wr_locked);
    txn_err = !addr_valid || wr_err;
    wr_ok   = accept && sys_read_write && addr_valid && !wr_err;
  end

  // Read data mux; unmapped offsets read as zero.
  always_comb begin
    read_val = '0;
    if (hit_scratch) begin
      read_val = scratch[scratch_idx];
    end else if (hit_ver_major) begin
      read_val = VER_MAJ_VAL;
    end else if (hit_ver_minor) begin
      read_val = VER_MIN_VAL;
    end else if (hit_ctrl) begin
      read_val = ctrl;
    end else if (hit_status) begin
      read_val = status;
    end else if (hit_irq_en) begin
      read_val = irq_en;
    end
  end

  // Bus response. The edge detector resets to "previously high" so a strobe
  // held through reset release must be seen low before it is accepted.
  // Read data is captured at acceptance and then held; errors return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_prev  <= 1'b1;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      sys_data_out <= '0;
    end else begin
      strobe_prev <= sys_strobe;
      ack_q       <= accept;
      if (accept) begin
        err_q <= txn_err;
        if (!addr_valid) begin
          sys_data_out <= '0;
        end else if (!sys_read_write) begin
          sys_data_out <= read_val;
        end
      end
    end
  end

  // The ack is withheld if the requester has already dropped its strobe;
  // a write is committed at acceptance regardless.
  always_comb begin
    sys_ack = ack_q && sys_strobe;
    sys_err = ack_q && sys_strobe && err_q;
  end

  // Scratch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch[i] <= '0;
      end
    end else if (wr_ok && hit_scratch) begin
      scratch[scratch_idx] <= sys_data_in;
    end
  end

  // CTRL and IRQ_EN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl   <= '0;
      irq_en <= '0;
    end else begin
      if (wr_ok && hit_ctrl) begin
        ctrl <= sys_data_in;
      end
      if (wr_ok && hit_irq_en) begin
        irq_en <= sys_data_in;
      end
    end
  end

  // STATUS: clear first, then OR in events, so an event arriving in the same
  // cycle as a clear of that bit leaves it set.
  assign w1c_mask = (wr_ok && hit_status) ? sys_data_in : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status <= '0;
    end else begin
      status <= (status & ~w1c_mask) | evt_in;
    end
  end

  // Interrupt follows the registered state with one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(status & irq_en);
    end
  end

  assign ctrl_out = ctrl;

endmodule
